// File: rtl/matrix_mult_driver.sv
// matrix_mult_driver: host-side sequencer for the 3x3 matrix multiplier.
// Accepts the operand nibbles from a valid/ready stream, clears and loads the
// multiplier, waits out its compute window, then sweeps the output-select
// address and re-emits each product with its index on a valid/ready stream.
module matrix_mult_driver #(
    parameter int N_IN  = 18,
    parameter int N_CMP = 9,
    parameter int N_OUT = 9
) (
    input  logic       ic,
    input  logic       mr,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [9:0] res_data,
    output logic [3:0] res_idx,
    output logic       res_last,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] mm_d,
    output logic       mm_en,
    output logic [3:0] mm_os,
    output logic       mm_mr,
    input  logic [9:0] mm_y
);

    localparam int LCW = $clog2(N_IN + 1);
    localparam int CCW = $clog2(N_CMP + 1);

    localparam logic [LCW-1:0] LOAD_LAST = LCW'(N_IN - 1);
    localparam logic [CCW-1:0] CMP_LAST  = CCW'(N_CMP - 1);
    localparam logic [3:0]     OUT_LAST  = 4'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_COMPUTE,
        S_RD_SET,
        S_RD_HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [LCW-1:0] load_cnt_q, load_cnt_d;
    logic [CCW-1:0] cmp_cnt_q, cmp_cnt_d;
    logic [3:0]     k_q, k_d;
    logic [9:0]     res_data_q, res_data_d;
    logic [3:0]     res_idx_q, res_idx_d;
    logic           res_last_q, res_last_d;
    logic           res_valid_q, res_valid_d;
    logic           done_q, done_d;
    logic           abort_clr_q, abort_clr_d;

    logic accept;
    logic res_fire;

    // Next-state, counter and result-register logic plus all combinational outputs
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        cmp_cnt_d   = cmp_cnt_q;
        k_d         = k_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_last_d  = res_last_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;
        abort_clr_d = abort;

        in_ready = 1'b0;
        mm_en    = 1'b0;
        mm_d     = 4'd0;
        mm_os    = 4'd0;
        busy     = (state_q != S_IDLE);
        // The multiplier is held clear for the whole of reset, during CLEAR,
        // and for one cycle after an abort so a cancelled job leaves no residue.
        mm_mr    = mr | (state_q == S_CLEAR) | abort_clr_q;

        accept   = (state_q == S_LOAD) && in_valid;
        res_fire = res_valid_q && res_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                load_cnt_d = '0;
                cmp_cnt_d  = '0;
                k_d        = 4'd0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                mm_d     = in_data;
                mm_en    = in_valid;
                if (accept) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == LOAD_LAST) begin
                        cmp_cnt_d = '0;
                        state_d   = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                mm_en = 1'b1;
                if (cmp_cnt_q == CMP_LAST) begin
                    k_d     = 4'd0;
                    state_d = S_RD_SET;
                end else begin
                    cmp_cnt_d = cmp_cnt_q + 1'b1;
                end
            end
            S_RD_SET: begin
                mm_en       = 1'b1;
                mm_os       = k_q;
                res_data_d  = mm_y;
                res_idx_d   = k_q;
                res_last_d  = (k_q == OUT_LAST);
                res_valid_d = 1'b1;
                state_d     = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                mm_en = 1'b1;
                mm_os = k_q;
                if (res_fire) begin
                    res_valid_d = 1'b0;
                    if (k_q == OUT_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        k_d     = k_q + 4'd1;
                        state_d = S_RD_SET;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
            done_d      = 1'b0;
        end

        res_data  = res_data_q;
        res_idx   = res_idx_q;
        res_last  = res_last_q;
        res_valid = res_valid_q;
        done      = done_q;
    end

    // State, counters and registered result stream with asynchronous reset
    always_ff @(posedge ic or posedge mr) begin
        if (mr) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            cmp_cnt_q   <= '0;
            k_q         <= 4'd0;
            res_data_q  <= 10'd0;
            res_idx_q   <= 4'd0;
            res_last_q  <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            cmp_cnt_q   <= cmp_cnt_d;
            k_q         <= k_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_last_q  <= res_last_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
            abort_clr_q <= abort_clr_d;
        end
    end

endmodule

// File: tb/tb_matrix_mult_driver.sv
// tb_matrix_mult_driver: randomized self-checking bench for matrix_mult_driver,
// with a behavioural 3x3 multiplier stub and a matrix-arithmetic reference.
module tb_matrix_mult_driver;

    typedef logic [3:0] job_t [18];
    typedef int         res_t [9];

    logic       ic = 1'b0;
    logic       mr;
    logic       start;
    logic       abort;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] res_data;
    logic [3:0] res_idx;
    logic       res_last;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic       done;
    logic [3:0] mm_d;
    logic       mm_en;
    logic [3:0] mm_os;
    logic       mm_mr;
    logic [9:0] mm_y;

    int checkCount = 0;
    int failCount  = 0;
    int cyc        = 0;

    matrix_mult_driver dut (
        .ic        (ic),
        .mr        (mr),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .res_last  (res_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .mm_d      (mm_d),
        .mm_en     (mm_en),
        .mm_os     (mm_os),
        .mm_mr     (mm_mr),
        .mm_y      (mm_y)
    );

    // 10-time-unit clock
    always #5 ic = ~ic;

    // Free-running cycle counter used for latency measurements
    always @(posedge ic) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Multiplier stub: records the first 18 enabled nibbles after a clear
    int         mmCnt = 0;
    logic [3:0] mmNib [18];

    always @(posedge ic) begin
        if (mm_mr) begin
            mmCnt <= 0;
        end else if (mm_en && mmCnt < 18) begin
            mmNib[mmCnt] <= mm_d;
            mmCnt        <= mmCnt + 1;
        end
    end

    // Stub product bus: selected element of A*B once fully loaded
    always_comb begin
        int acc;
        int row;
        int col;
        acc = 0;
        row = int'(mm_os) / 3;
        col = int'(mm_os) % 3;
        if (mmCnt == 18 && mm_os < 4'd9) begin
            for (int t = 0; t < 3; t++) begin
                acc += int'(mmNib[row*3+t]) * int'(mmNib[9+col*3+t]);
            end
        end
        mm_y = 10'(acc);
    end

    // Reference: A row-major, B column-major, C = A*B reported row-major
    function automatic res_t refProducts(input job_t nib);
        int   a [3][3];
        int   b [3][3];
        res_t r;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                a[i][j] = int'(nib[3*i+j]);
                b[j][i] = int'(nib[9+3*i+j]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r[3*i+j] = a[i][0]*b[0][j] + a[i][1]*b[1][j] + a[i][2]*b[2][j];
            end
        end
        return r;
    endfunction

    function automatic job_t randJob();
        job_t n;
        for (int i = 0; i < 18; i++) n[i] = 4'($urandom_range(0, 15));
        return n;
    endfunction

    // Output monitor: records handshakes and done pulses, checks stream rules
    int         gotData [$];
    int         gotIdx  [$];
    int         gotLast [$];
    int         gotCyc  [$];
    int         doneCnt = 0;
    int         doneCyc = 0;
    logic       holdPrev = 1'b0;
    logic [9:0] prevData;
    logic [3:0] prevIdx;
    logic [3:0] prevOs;

    always @(negedge ic) begin
        if (mr) begin
            holdPrev = 1'b0;
        end else begin
            if (in_ready) begin
                checkOutput("mm_en_follows_in_valid", mm_en, in_valid);
                if (in_valid) checkOutput("mm_d_follows_in_data", mm_d, in_data);
            end
            if (holdPrev) begin
                checkOutput("hold_valid", res_valid, 1);
                checkOutput("hold_data", res_data, prevData);
                checkOutput("hold_idx", res_idx, prevIdx);
                checkOutput("hold_mm_os", mm_os, prevOs);
            end
            if (res_valid) checkOutput("res_last_iff_idx8", res_last, res_idx == 4'd8);
            if (res_valid && res_ready) begin
                gotData.push_back(int'(res_data));
                gotIdx.push_back(int'(res_idx));
                gotLast.push_back(int'(res_last));
                gotCyc.push_back(cyc);
            end
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            holdPrev = res_valid && !res_ready && !abort;
            prevData = res_data;
            prevIdx  = res_idx;
            prevOs   = mm_os;
        end
    end

    task automatic startJob(output int c0);
        gotData.delete();
        gotIdx.delete();
        gotLast.delete();
        gotCyc.delete();
        doneCnt = 0;
        start = 1'b1;
        c0    = cyc;
        @(posedge ic); #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input job_t nib, input int count, input bit stall);
        int idx   = 0;
        int guard = 0;
        bit gap   = stall;
        while (idx < count && guard < 200) begin
            in_valid = !(stall && gap);
            in_data  = nib[idx];
            @(negedge ic);
            if (in_ready) begin
                if (in_valid) begin
                    idx++;
                    gap = stall;
                end else begin
                    gap = 1'b0;
                end
            end
            @(posedge ic); #1;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = 4'd0;
        checkOutput("input_accepts", idx, count);
    endtask

    task automatic runJob(input string tag, input job_t nib, input res_t expv, input bit stall,
                          input int holdIdx, input int holdLen, input int firstExp, input int doneExp);
        int c0;
        int holdCnt = 0;
        int guard   = 0;
        startJob(c0);
        applyStimulus(nib, 18, stall);
        while (doneCnt == 0 && guard < 400) begin
            if (res_valid && int'(res_idx) == holdIdx && holdCnt < holdLen) begin
                res_ready = 1'b0;
                holdCnt++;
            end else begin
                res_ready = 1'b1;
            end
            @(posedge ic); #1;
            guard++;
        end
        res_ready = 1'b1;
        repeat (2) @(posedge ic);
        #1;
        checkOutput({tag, "_done_once"}, doneCnt, 1);
        checkOutput({tag, "_busy_after"}, busy, 0);
        checkOutput({tag, "_count"}, gotData.size(), 9);
        for (int i = 0; i < gotData.size() && i < 9; i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), gotData[i], expv[i]);
            checkOutput($sformatf("%s_idx%0d", tag, i), gotIdx[i], i);
            checkOutput($sformatf("%s_last%0d", tag, i), gotLast[i], i == 8);
        end
        if (firstExp >= 0 && gotCyc.size() > 0) checkOutput({tag, "_first_valid_cycle"}, gotCyc[0] - c0, firstExp);
        if (doneExp >= 0 && doneCnt > 0) checkOutput({tag, "_done_cycle"}, doneCyc - c0, doneExp);
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        failCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        job_t idJob;
        job_t j;
        res_t idExp;
        res_t fullExp;
        int   c0;

        mr        = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        res_ready = 1'b1;
        repeat (3) @(posedge ic);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_last", res_last, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_mm_en", mm_en, 0);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_res_idx", res_idx, 0);
        checkOutput("rst_mm_d", mm_d, 0);
        checkOutput("rst_mm_os", mm_os, 0);
        checkOutput("rst_mm_mr", mm_mr, 1);
        mr = 1'b0;
        @(posedge ic); #1;
        checkOutput("post_rst_mm_mr", mm_mr, 0);

        start = 1'b1;
        abort = 1'b1;
        @(posedge ic); #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_idle_busy", busy, 0);
        @(posedge ic); #1;

        idJob = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1,
                  4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        idExp = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
        runJob("identity", idJob, idExp, 1'b0, -1, 0, 30, 47);

        for (int i = 0; i < 18; i++) j[i] = 4'd15;
        for (int i = 0; i < 9; i++) fullExp[i] = 675;
        runJob("all15", j, fullExp, 1'b0, -1, 0, 30, 47);

        j = randJob();
        runJob("rand_nostall", j, refProducts(j), 1'b0, -1, 0, 30, 47);
        runJob("rand_stall", j, refProducts(j), 1'b1, -1, 0, 48, 65);

        j = randJob();
        runJob("hold_idx3", j, refProducts(j), 1'b0, 3, 5, 30, 52);

        j = randJob();
        startJob(c0);
        applyStimulus(j, 10, 1'b0);
        abort = 1'b1;
        @(posedge ic); #1;
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_mm_mr_pulse", mm_mr, 1);
        checkOutput("abort_res_valid", res_valid, 0);
        @(posedge ic); #1;
        checkOutput("abort_mm_mr_end", mm_mr, 0);
        checkOutput("abort_no_done", doneCnt, 0);
        j = randJob();
        runJob("after_abort", j, refProducts(j), 1'b0, -1, 0, 30, 47);

        j = randJob();
        startJob(c0);
        applyStimulus(j, 18, 1'b0);
        repeat (3) @(posedge ic);
        #3;
        mr = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_mm_mr", mm_mr, 1);
        checkOutput("midrst_mm_en", mm_en, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_res_valid", res_valid, 0);
        checkOutput("midrst_mm_os", mm_os, 0);
        start = 1'b1;
        repeat (3) @(posedge ic);
        #1;
        checkOutput("midrst_start_ignored", busy, 0);
        start = 1'b0;
        #1;
        mr = 1'b0;
        @(posedge ic); #1;
        checkOutput("midrst_idle_after", busy, 0);
        checkOutput("midrst_no_done", doneCnt, 0);
        j = randJob();
        runJob("after_reset", j, refProducts(j), 1'b0, -1, 0, 30, 47);

        for (int n = 0; n < 3; n++) begin
            j = randJob();
            runJob($sformatf("rand%0d", n), j, refProducts(j), n[0], -1, 0, -1, n[0] ? 65 : 47);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
